// File: rtl/la_iocut_seq_pkg.sv
// Shared state encoding for the io-ring cut-cell power sequencer.
package la_iocut_seq_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_UP    = 3'd1,
        ST_READY = 3'd2,
        ST_DOWN  = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

endpackage

// File: rtl/la_iocut_seq_cnt.sv
// Loadable settle down-counter; holds at zero instead of wrapping.
module la_iocut_seq_cnt
    import la_iocut_seq_pkg::*;
#(
    parameter int CNTW = 8
) (
    input  logic            i_clk,
    input  logic            i_nreset,
    input  logic            i_load,
    input  logic [CNTW-1:0] i_load_val,
    output logic            o_zero
);

    logic [CNTW-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_nreset) begin
        if (!i_nreset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/la_iocut_seq.sv
// Power-up/down sequencer for io-ring segments separated by cut cells.
// Define LA_IOCUT_PGCHK_EN to enable power-good checking and the FAULT state.
module la_iocut_seq
    import la_iocut_seq_pkg::*;
#(
    parameter     PROP = "DEFAULT",
    parameter     SIDE = "NO",
    parameter int NSEG = 4,
    parameter int CNTW = 8
) (
    input  logic            clk,
    input  logic            nreset,
    input  logic            en,
    input  logic [CNTW-1:0] settle,
    input  logic [NSEG-1:0] seg_pg,
    output logic [NSEG-1:0] seg_en,
    output logic [NSEG-1:0] seg_iso,
    output logic            ready,
    output logic            fault,
    output logic [NSEG-1:0] fault_mask
);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [NSEG-1:0] r_seg_en;
    logic [NSEG-1:0] w_seg_en_nxt;
    logic [NSEG-1:0] r_fault_mask;
    logic [NSEG-1:0] w_mask_nxt;
    logic            w_cnt_load;
    logic            w_cnt_zero;
    logic [NSEG-1:0] w_top;
    logic            w_up_fail;
    logic [NSEG-1:0] w_rdy_fail;
    logic            w_unused_cfg;

    assign w_unused_cfg = ^{PROP, SIDE};

    la_iocut_seq_cnt #(
        .CNTW(CNTW)
    ) u_cnt (
        .i_clk     (clk),
        .i_nreset  (nreset),
        .i_load    (w_cnt_load),
        .i_load_val(settle),
        .o_zero    (w_cnt_zero)
    );

    // One-hot marker of the segment currently being brought up (top enabled bit).
    assign w_top = r_seg_en & ~(r_seg_en >> 1);

`ifdef LA_IOCUT_PGCHK_EN
    assign w_up_fail  = ((seg_pg & w_top) == '0);
    assign w_rdy_fail = r_seg_en & ~seg_pg;
    assign fault      = (r_state == ST_FAULT);
    assign fault_mask = r_fault_mask;
`else
    logic w_unused_pg;
    assign w_unused_pg = ^{seg_pg, r_fault_mask};
    assign w_up_fail   = 1'b0;
    assign w_rdy_fail  = '0;
    assign fault       = 1'b0;
    assign fault_mask  = '0;
`endif

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state      <= ST_IDLE;
            r_seg_en     <= '0;
            r_fault_mask <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_seg_en     <= w_seg_en_nxt;
            r_fault_mask <= w_mask_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_seg_en_nxt = r_seg_en;
        w_mask_nxt   = r_fault_mask;
        w_cnt_load   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (en) begin
                    w_seg_en_nxt = NSEG'(1);
                    w_cnt_load   = 1'b1;
                    w_state_nxt  = ST_UP;
                end
            end
            ST_UP: begin
                if (!en) begin
                    w_cnt_load  = 1'b1;
                    w_state_nxt = ST_DOWN;
                end else if (w_cnt_zero) begin
                    if (w_up_fail) begin
                        w_seg_en_nxt = '0;
                        w_mask_nxt   = w_top;
                        w_state_nxt  = ST_FAULT;
                    end else if (r_seg_en[NSEG-1]) begin
                        w_state_nxt = ST_READY;
                    end else begin
                        w_seg_en_nxt = (r_seg_en << 1) | NSEG'(1);
                        w_cnt_load   = 1'b1;
                    end
                end
            end
            ST_READY: begin
                if (!en) begin
                    w_cnt_load  = 1'b1;
                    w_state_nxt = ST_DOWN;
                end else if (|w_rdy_fail) begin
                    w_seg_en_nxt = '0;
                    w_mask_nxt   = w_rdy_fail;
                    w_state_nxt  = ST_FAULT;
                end
            end
            ST_DOWN: begin
                // en is deliberately not looked at until the ring is fully off.
                if (w_cnt_zero) begin
                    w_seg_en_nxt = r_seg_en >> 1;
                    if ((r_seg_en >> 1) == '0) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_cnt_load = 1'b1;
                    end
                end
            end
            ST_FAULT: begin
                w_seg_en_nxt = '0;
                if (!en) begin
                    w_mask_nxt  = '0;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_seg_en_nxt = '0;
                w_mask_nxt   = '0;
                w_state_nxt  = ST_IDLE;
            end
        endcase
    end

    assign seg_en  = r_seg_en;
    assign seg_iso = (r_state == ST_READY) ? '0 : '1;
    assign ready   = (r_state == ST_READY);

endmodule

// File: doc/la_iocut_seq.md
LA_IOCUT_SEQ -- requirements
Module: la_iocut_seq

Interface
REQ-001 SHALL have parameter PROP, default "DEFAULT"; cell property string, passed through, no functional effect.
REQ-002 SHALL have parameter SIDE, default "NO"; ring side "NO"/"SO"/"EA"/"WE", no functional effect.
REQ-003 SHALL have parameter NSEG, default 4; number of io-ring segments separated by cut cells, range 1..16.
REQ-004 SHALL have parameter CNTW, default 8; settle counter width.
REQ-005 SHALL have one clock, clk, and an asynchronous active-low reset, nreset.
REQ-006 SHALL have the ports below:
- clk  input  1  sequencer clock.
- nreset  input  1  async active-low reset.
- en  input  1  request all segments powered.
- settle  input  CNTW  settle cycles per segment, S; static while not IDLE.
- seg_pg  input  NSEG  per-segment power-good.
- seg_en  output  NSEG  per-segment supply enable.
- seg_iso  output  NSEG  per-segment isolation, 1 = isolated.
- ready  output  1  all segments enabled and de-isolated.
- fault  output  1  power-good failure flag.
- fault_mask  output  NSEG  failing segment(s).

Function
REQ-007 SHALL implement states IDLE, UP, READY, DOWN, FAULT.
REQ-008 In IDLE with en=1 at edge k, SHALL set seg_en[0]=1, load the counter with S and enter UP at k+1.
REQ-009 In UP, the counter SHALL decrement once per cycle. At count 0, with seg_pg[i]=1 and i<NSEG-1, it SHALL set seg_en[i+1] and reload S, so each segment takes S+1 cycles.
REQ-010 At count 0 in UP with i=NSEG-1 and seg_pg[i]=1, SHALL enter READY: seg_iso=0 and ready=1, both visible NSEG*(S+1)+1 cycles after en is sampled.
REQ-011 S=0 SHALL give one cycle per segment; the counter SHALL never wrap below 0.
REQ-012 In UP or READY with en=0, SHALL enter DOWN: seg_iso all 1 and ready=0 the next cycle, counter loaded with S.
REQ-013 In DOWN, at count 0 SHALL clear the highest set seg_en bit and reload. When seg_en=0, SHALL enter IDLE.
REQ-014 en re-asserted during DOWN SHALL be ignored until IDLE is reached.
REQ-015 seg_en SHALL always be a thermometer code, from bit 0 upward.
REQ-016 A power-good failure SHALL enter FAULT the next cycle. A failure is seg_pg[i]=0 at count 0 in UP, or any enabled seg_pg=0 in READY.
REQ-017 In FAULT: seg_en=0, seg_iso all 1, ready=0, fault=1, and fault_mask holds the failing bit(s) latched on entry.
REQ-018 FAULT SHALL persist while en=1. With en=0, SHALL go to IDLE and clear fault and fault_mask.
REQ-019 seg_pg SHALL be ignored in IDLE and DOWN.

Reset
REQ-020 nreset low SHALL asynchronously force IDLE, seg_en=0, seg_iso all 1, ready=0, fault=0, fault_mask=0 and counter=0.
REQ-021 Reset asserted mid-UP or mid-DOWN SHALL drop all enables immediately, with no reverse sequencing.
REQ-022 The first transition after reset release SHALL need en sampled high on a clk edge.

Configuration
REQ-023 Macro LA_IOCUT_PGCHK_EN defined: power-good checking active, per REQ-016 to REQ-018.
REQ-024 LA_IOCUT_PGCHK_EN undefined:
- seg_pg unused;
- FAULT unreachable;
- fault and fault_mask tied 0;
- UP advances on count 0 alone.

Structure
REQ-025 Package la_iocut_seq_pkg SHALL hold the state enum and the state-width constant.
REQ-026 Sub-module la_iocut_seq_cnt SHALL implement the loadable CNTW-bit down-counter with a zero flag, instantiated once.

Verification (NSEG=4, CNTW=8)
REQ-027 S=3, en=1 at edge 0, all pg=1: seg_en steps 0001/0011/0111/1111 at cycles 1/5/9/13, and ready=1 with seg_iso=0000 at cycle 17.
REQ-028 From READY with S=3, en=0: iso=1111 and ready=0 the next cycle, then seg_en steps 0111/0011/0001/0000 every 4 cycles, then IDLE.
REQ-029 S=2, seg_pg[2] held 0: at segment 2's count 0, next cycle fault=1, fault_mask=0100, seg_en=0000; en=0 returns to IDLE with fault=0.
REQ-030 S=0: seg_en fills one bit per cycle and ready is high 5 cycles after en.
REQ-031 nreset pulsed low mid-UP (seg_en=0011): outputs reach reset values without a clk edge, and en high after release restarts from seg_en=0001.
REQ-032 Build without LA_IOCUT_PGCHK_EN, seg_pg=0000, S=1: ready=1 at cycle 9 and fault stays 0.
